// File: rtl/usb_fifo_pkg.sv
// rtl/usb_fifo_pkg.sv - shared constants and types for the FT-style FIFO host model
package usb_fifo_pkg;
  localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0]  SYNC_BYTE     = 8'hD5;
  localparam int          PRE_LEN       = 8;
  localparam int          HDR_LEN       = 8;
  localparam logic [23:0] TAG_RX0       = 24'h525830;
  localparam logic [23:0] TAG_BS0       = 24'h425330;

  typedef enum logic [1:0] {
    PKT_NONE    = 2'd0,
    PKT_RX0     = 2'd1,
    PKT_BS0     = 2'd2,
    PKT_UNKNOWN = 2'd3
  } pkt_type_t;

  typedef enum logic [1:0] {P_HUNT, P_HDR, P_DATA} parse_state_t;

  typedef enum logic {SRV_IDLE, SRV_SEND} srv_state_t;

  function automatic pkt_type_t tag_to_type(input logic [23:0] tag);
    if (tag == TAG_RX0) return PKT_RX0;
    if (tag == TAG_BS0) return PKT_BS0;
    return PKT_UNKNOWN;
  endfunction
endpackage

// File: rtl/usb_pkt_parser.sv
// rtl/usb_pkt_parser.sv - uplink packet parser: preamble hunt, header decode, payload stream
module usb_pkt_parser
  import usb_fifo_pkg::*;
#(
  parameter int PAY_LEN = 492
) (
  input  logic        usb_clock,
  input  logic        reset,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        hunting,
  output logic [1:0]  pkt_type,
  output logic [15:0] pkt_fw,
  output logic        pkt_clip,
  output logic [7:0]  pkt_pn,
  output logic [7:0]  pkt_data,
  output logic        pkt_data_valid,
  output logic        pkt_sof,
  output logic        pkt_eof,
  output logic [7:0]  sync_err_cnt,
  output logic [15:0] rx_pkt_cnt,
  output logic [15:0] bs_pkt_cnt
);
  localparam int DW = $clog2(PAY_LEN);

  parse_state_t  state, state_nx;
  logic [2:0]    pcnt, hcnt;
  logic [DW-1:0] dcnt;
  logic [55:0]   hdr;
  logic [63:0]   hdr_full;
  logic          last_pay;

  assign hdr_full = {hdr, byte_data};
  assign last_pay = (dcnt == DW'(PAY_LEN - 1));
  assign hunting  = (state == P_HUNT);

  always_comb begin
    state_nx = state;
    if (byte_valid) begin
      case (state)
        P_HUNT:  if (byte_data == SYNC_BYTE && pcnt == 3'd7) state_nx = P_HDR;
        P_HDR:   if (hcnt == 3'(HDR_LEN - 1)) state_nx = P_DATA;
        P_DATA:  if (last_pay) state_nx = P_HUNT;
        default: state_nx = P_HUNT;
      endcase
    end
  end

  always_ff @(posedge usb_clock or posedge reset) begin
    if (reset) state <= P_HUNT;
    else       state <= state_nx;
  end

  always_ff @(posedge usb_clock or posedge reset) begin
    if (reset) begin
      pcnt           <= '0;
      hcnt           <= '0;
      dcnt           <= '0;
      hdr            <= '0;
      pkt_type       <= PKT_NONE;
      pkt_fw         <= '0;
      pkt_clip       <= 1'b0;
      pkt_pn         <= '0;
      pkt_data       <= '0;
      pkt_data_valid <= 1'b0;
      pkt_sof        <= 1'b0;
      pkt_eof        <= 1'b0;
      sync_err_cnt   <= '0;
      rx_pkt_cnt     <= '0;
      bs_pkt_cnt     <= '0;
    end else begin
      pkt_data_valid <= 1'b0;
      pkt_sof        <= 1'b0;
      pkt_eof        <= 1'b0;
      if (byte_valid) begin
        case (state)
          P_HUNT: begin
            hcnt <= '0;
            dcnt <= '0;
            if (byte_data == PREAMBLE_BYTE) begin
              if (pcnt != 3'd7) pcnt <= pcnt + 3'd1;
            end else if (byte_data == SYNC_BYTE && pcnt == 3'd7) begin
              pcnt <= '0;
            end else begin
              // A broken preamble only counts once some 55h bytes were seen.
              pcnt <= '0;
              if (pcnt != 3'd0 && sync_err_cnt != 8'hFF) sync_err_cnt <= sync_err_cnt + 8'd1;
            end
          end
          P_HDR: begin
            hdr  <= hdr_full[55:0];
            hcnt <= hcnt + 3'd1;
            if (hcnt == 3'(HDR_LEN - 1)) begin
              pkt_type <= tag_to_type(hdr_full[63:40]);
              pkt_fw   <= hdr_full[39:24];
              pkt_clip <= hdr_full[16];
              pkt_pn   <= hdr_full[15:8];
            end
          end
          P_DATA: begin
            pkt_data       <= byte_data;
            pkt_data_valid <= 1'b1;
            pkt_sof        <= (dcnt == '0);
            pkt_eof        <= last_pay;
            dcnt           <= dcnt + DW'(1);
            if (last_pay) begin
              if (pkt_type == PKT_RX0) rx_pkt_cnt <= rx_pkt_cnt + 16'd1;
              if (pkt_type == PKT_BS0) bs_pkt_cnt <= bs_pkt_cnt + 16'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: rtl/usb_fifo_host.sv
// rtl/usb_fifo_host.sv - FIFO-chip side of the sync FIFO link: command server plus uplink capture
module usb_fifo_host
  import usb_fifo_pkg::*;
#(
  parameter int PAY_LEN = 492,
  parameter int CMD_LEN = 24
) (
  input  logic                 usb_clock,
  input  logic                 reset,
  inout  wire  [7:0]           usb_data,
  input  logic                 n_RD,
  input  logic                 n_WR,
  input  logic                 n_OE,
  input  logic                 n_SIWU,
  output logic                 n_RXF,
  output logic                 n_TXE,
  input  logic                 cmd_valid,
  input  logic [8*CMD_LEN-1:0] cmd_header,
  output logic                 cmd_ready,
  input  logic                 tx_stall,
  output logic [1:0]           pkt_type,
  output logic [15:0]          pkt_fw,
  output logic                 pkt_clip,
  output logic [7:0]           pkt_pn,
  output logic [7:0]           pkt_data,
  output logic                 pkt_data_valid,
  output logic                 pkt_sof,
  output logic                 pkt_eof,
  output logic                 siwu_pulse,
  output logic [7:0]           sync_err_cnt,
  output logic [15:0]          rx_pkt_cnt,
  output logic [15:0]          bs_pkt_cnt
);
  localparam int FRM_LEN = PRE_LEN + CMD_LEN;
  localparam int FW      = 8 * FRM_LEN;
  localparam int IW      = $clog2(FRM_LEN);

  srv_state_t      srv_state, srv_nx;
  logic [FW-1:0]   frame;
  logic [IW-1:0]   rd_idx;
  logic            alive_q, n_txe_q, siwu_q, hunting;
  logic            accept, consume, last_byte;

  assign cmd_ready = alive_q && (srv_state == SRV_IDLE);
  assign n_RXF     = (srv_state != SRV_SEND);
  assign accept    = cmd_valid && cmd_ready;
  assign consume   = (srv_state == SRV_SEND) && !n_RD;
  assign last_byte = (rd_idx == IW'(FRM_LEN - 1));
  assign n_TXE     = n_txe_q;
  assign usb_data  = (!n_OE && srv_state == SRV_SEND) ? frame[FW-1 -: 8] : 8'hzz;

  always_comb begin
    srv_nx = srv_state;
    case (srv_state)
      SRV_IDLE: if (accept) srv_nx = SRV_SEND;
      SRV_SEND: if (consume && last_byte) srv_nx = SRV_IDLE;
      default:  srv_nx = SRV_IDLE;
    endcase
  end

  always_ff @(posedge usb_clock or posedge reset) begin
    if (reset) srv_state <= SRV_IDLE;
    else       srv_state <= srv_nx;
  end

  // The frame shifts left on each consumed byte so the bus always shows the top byte.
  always_ff @(posedge usb_clock or posedge reset) begin
    if (reset) begin
      frame  <= '0;
      rd_idx <= '0;
    end else if (accept) begin
      frame  <= {{7{PREAMBLE_BYTE}}, SYNC_BYTE, cmd_header};
      rd_idx <= '0;
    end else if (consume) begin
      frame  <= {frame[FW-9:0], 8'h00};
      rd_idx <= rd_idx + IW'(1);
    end
  end

  always_ff @(posedge usb_clock or posedge reset) begin
    if (reset) begin
      alive_q    <= 1'b0;
      n_txe_q    <= 1'b1;
      siwu_q     <= 1'b1;
      siwu_pulse <= 1'b0;
    end else begin
      alive_q    <= 1'b1;
      siwu_q     <= n_SIWU;
      siwu_pulse <= siwu_q && !n_SIWU;
      // Flow control may only move between packets.
      if (alive_q && hunting) n_txe_q <= tx_stall;
    end
  end

  usb_pkt_parser #(.PAY_LEN(PAY_LEN)) u_parser (
    .usb_clock      (usb_clock),
    .reset          (reset),
    .byte_valid     (!n_WR && !n_txe_q),
    .byte_data      (usb_data),
    .hunting        (hunting),
    .pkt_type       (pkt_type),
    .pkt_fw         (pkt_fw),
    .pkt_clip       (pkt_clip),
    .pkt_pn         (pkt_pn),
    .pkt_data       (pkt_data),
    .pkt_data_valid (pkt_data_valid),
    .pkt_sof        (pkt_sof),
    .pkt_eof        (pkt_eof),
    .sync_err_cnt   (sync_err_cnt),
    .rx_pkt_cnt     (rx_pkt_cnt),
    .bs_pkt_cnt     (bs_pkt_cnt)
  );
endmodule

// File: tb/tb_usb_fifo_host.sv
// tb/tb_usb_fifo_host.sv - self-checking bench for usb_fifo_host
module tb_usb_fifo_host;
  import usb_fifo_pkg::*;

  localparam int PAY = 492;

  logic usb_clock = 1'b0;
  logic reset = 1'b1;
  logic n_RD = 1'b1, n_WR = 1'b1, n_OE = 1'b1, n_SIWU = 1'b1;
  logic cmd_valid = 1'b0, tx_stall = 1'b0;
  logic [191:0] cmd_header = '0;
  logic tb_drv = 1'b0;
  logic [7:0] tb_byte = 8'h00;
  wire  [7:0] usb_data;
  logic n_RXF, n_TXE, cmd_ready, pkt_clip, pkt_data_valid, pkt_sof, pkt_eof, siwu_pulse;
  logic [1:0] pkt_type;
  logic [15:0] pkt_fw, rx_pkt_cnt, bs_pkt_cnt;
  logic [7:0] pkt_pn, pkt_data, sync_err_cnt;

  assign usb_data = tb_drv ? tb_byte : 8'hzz;

  usb_fifo_host dut (
    .usb_clock(usb_clock), .reset(reset), .usb_data(usb_data),
    .n_RD(n_RD), .n_WR(n_WR), .n_OE(n_OE), .n_SIWU(n_SIWU),
    .n_RXF(n_RXF), .n_TXE(n_TXE), .cmd_valid(cmd_valid), .cmd_header(cmd_header),
    .cmd_ready(cmd_ready), .tx_stall(tx_stall), .pkt_type(pkt_type), .pkt_fw(pkt_fw),
    .pkt_clip(pkt_clip), .pkt_pn(pkt_pn), .pkt_data(pkt_data),
    .pkt_data_valid(pkt_data_valid), .pkt_sof(pkt_sof), .pkt_eof(pkt_eof),
    .siwu_pulse(siwu_pulse), .sync_err_cnt(sync_err_cnt),
    .rx_pkt_cnt(rx_pkt_cnt), .bs_pkt_cnt(bs_pkt_cnt)
  );

  always #5 usb_clock = ~usb_clock;

  typedef struct {
    logic [7:0] data;
    logic       sof;
    logic       eof;
  } exp_t;

  typedef struct {
    logic [23:0] tag;
    logic [15:0] fw;
    logic [7:0]  flags;
    logic [7:0]  pn;
    int          pre;
    bit          junk;
    logic [7:0]  seed;
    logic [1:0]  e_type;
    logic [15:0] e_rx;
    logic [15:0] e_bs;
    logic [7:0]  e_err;
  } vec_t;

  exp_t sb[$];
  int n_compared = 0;
  int n_mismatched = 0;
  int siwu_seen = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_compared++;
    if (act !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Payload scoreboard and SIWU pulse counter, sampled on the falling edge.
  always @(negedge usb_clock) begin
    if (siwu_pulse) siwu_seen++;
    if (pkt_data_valid) begin
      if (sb.size() == 0) begin
        n_compared++;
        n_mismatched++;
        $display("FAIL payload_unexpected: got byte %0h with empty scoreboard", pkt_data);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("pay_data", {24'h0, pkt_data}, {24'h0, e.data});
        chk("pay_sof", {31'h0, pkt_sof}, {31'h0, e.sof});
        chk("pay_eof", {31'h0, pkt_eof}, {31'h0, e.eof});
      end
    end
  end

  task automatic wr(input logic [7:0] b);
    tb_byte = b;
    tb_drv  = 1'b1;
    n_WR    = 1'b0;
    @(negedge usb_clock);
  endtask

  task automatic wr_idle();
    n_WR   = 1'b1;
    tb_drv = 1'b0;
  endtask

  task automatic send_pkt(input vec_t v, input int npay);
    logic [7:0] d;
    exp_t e;
    if (v.junk) begin
      wr(8'h55); wr(8'h55); wr(8'h00);
    end
    for (int i = 0; i < v.pre; i++) wr(8'h55);
    wr(8'hD5);
    wr(v.tag[23:16]); wr(v.tag[15:8]); wr(v.tag[7:0]);
    wr(v.fw[15:8]); wr(v.fw[7:0]); wr(v.flags); wr(v.pn); wr(8'h00);
    for (int i = 0; i < npay; i++) begin
      d = 8'(i) + v.seed;
      e.data = d;
      e.sof  = (i == 0);
      e.eof  = (i == PAY - 1);
      sb.push_back(e);
      wr(d);
    end
    wr_idle();
  endtask

  task automatic chk_fields(input string tag, input vec_t v);
    chk({tag, "_type"}, {30'h0, pkt_type}, {30'h0, v.e_type});
    chk({tag, "_fw"}, {16'h0, pkt_fw}, {16'h0, v.fw});
    chk({tag, "_clip"}, {31'h0, pkt_clip}, {31'h0, v.flags[0]});
    chk({tag, "_pn"}, {24'h0, pkt_pn}, {24'h0, v.pn});
    chk({tag, "_rx_cnt"}, {16'h0, rx_pkt_cnt}, {16'h0, v.e_rx});
    chk({tag, "_bs_cnt"}, {16'h0, bs_pkt_cnt}, {16'h0, v.e_bs});
    chk({tag, "_sync_err"}, {24'h0, sync_err_cnt}, {24'h0, v.e_err});
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[5];
    vec_t vr;
    logic [7:0] exp_frame[32];

    vecs[0] = '{24'h525830, 16'h3130, 8'h01, 8'h00, 7, 1'b0, 8'h00, 2'd1, 16'd1, 16'd0, 8'd0};
    vecs[1] = '{24'h425330, 16'h0102, 8'h00, 8'h42, 7, 1'b0, 8'h10, 2'd2, 16'd1, 16'd1, 8'd0};
    vecs[2] = '{24'h525830, 16'h3130, 8'h01, 8'h07, 7, 1'b1, 8'h33, 2'd1, 16'd2, 16'd1, 8'd1};
    vecs[3] = '{24'h525830, 16'hABCD, 8'hFE, 8'h99, 9, 1'b0, 8'h80, 2'd1, 16'd3, 16'd1, 8'd1};
    vecs[4] = '{24'h58595A, 16'h0000, 8'h01, 8'h01, 7, 1'b0, 8'h05, 2'd3, 16'd3, 16'd1, 8'd1};

    // Reset state
    repeat (3) @(negedge usb_clock);
    chk("rst_n_rxf", {31'h0, n_RXF}, 32'd1);
    chk("rst_n_txe", {31'h0, n_TXE}, 32'd1);
    chk("rst_cmd_ready", {31'h0, cmd_ready}, 32'd0);
    chk("rst_pkt_type", {30'h0, pkt_type}, 32'd0);
    chk("rst_pkt_valid", {31'h0, pkt_data_valid}, 32'd0);
    chk("rst_siwu", {31'h0, siwu_pulse}, 32'd0);
    chk("rst_counters", {sync_err_cnt, rx_pkt_cnt[7:0], bs_pkt_cnt[7:0], pkt_pn}, 32'd0);
    reset = 1'b0;
    @(negedge usb_clock);
    chk("post_rst1_cmd_ready", {31'h0, cmd_ready}, 32'd1);
    chk("post_rst1_n_txe", {31'h0, n_TXE}, 32'd1);
    @(negedge usb_clock);
    chk("post_rst2_n_txe", {31'h0, n_TXE}, 32'd0);

    // Command serving
    cmd_header = {24'h525830, 8'h01, 8'h30, 32'h00E4E1C0, 8'h00, 112'h0};
    for (int i = 0; i < 7; i++) exp_frame[i] = 8'h55;
    exp_frame[7] = 8'hD5;
    for (int i = 0; i < 24; i++) exp_frame[8+i] = cmd_header[191-8*i -: 8];
    cmd_valid = 1'b1;
    @(negedge usb_clock);
    cmd_valid = 1'b0;
    chk("cmd_n_rxf_low", {31'h0, n_RXF}, 32'd0);
    chk("cmd_busy", {31'h0, cmd_ready}, 32'd0);
    n_OE = 1'b0;
    n_RD = 1'b0;
    for (int i = 0; i < 32; i++) begin
      #1;
      chk($sformatf("cmd_byte%0d", i), {24'h0, usb_data}, {24'h0, exp_frame[i]});
      @(negedge usb_clock);
    end
    chk("cmd_done_n_rxf", {31'h0, n_RXF}, 32'd1);
    chk("cmd_done_ready", {31'h0, cmd_ready}, 32'd1);
    tb_byte = 8'hA5;
    tb_drv  = 1'b1;
    #1;
    chk("cmd_done_bus_released", {24'h0, usb_data}, 32'hA5);
    tb_drv = 1'b0;
    n_RD = 1'b1;
    n_OE = 1'b1;
    @(negedge usb_clock);

    // Packet vectors
    for (int k = 0; k < 5; k++) begin
      send_pkt(vecs[k], PAY);
      repeat (2) @(negedge usb_clock);
      chk_fields($sformatf("vec%0d", k), vecs[k]);
    end

    // Stall and SIWU
    tx_stall = 1'b1;
    @(negedge usb_clock);
    chk("stall_n_txe", {31'h0, n_TXE}, 32'd1);
    wr(8'h55); wr(8'h55); wr(8'h00);
    wr_idle();
    @(negedge usb_clock);
    chk("stall_ignored", {24'h0, sync_err_cnt}, 32'd1);
    siwu_seen = 0;
    n_SIWU = 1'b0;
    @(negedge usb_clock);
    n_SIWU = 1'b1;
    repeat (3) @(negedge usb_clock);
    chk("siwu_pulses", siwu_seen, 32'd1);
    tx_stall = 1'b0;
    repeat (2) @(negedge usb_clock);
    chk("unstall_n_txe", {31'h0, n_TXE}, 32'd0);

    // Reset mid-payload
    send_pkt(vecs[0], 100);
    @(negedge usb_clock);
    reset = 1'b1;
    #1;
    chk("midrst_pkt_type", {30'h0, pkt_type}, 32'd0);
    chk("midrst_valid", {31'h0, pkt_data_valid}, 32'd0);
    chk("midrst_counters", {sync_err_cnt, rx_pkt_cnt[7:0], bs_pkt_cnt[7:0], 8'h0}, 32'd0);
    chk("midrst_n_txe", {31'h0, n_TXE}, 32'd1);
    chk("midrst_fw", {16'h0, pkt_fw}, 32'd0);
    @(negedge usb_clock);
    reset = 1'b0;
    repeat (3) @(negedge usb_clock);
    vr = vecs[0];
    vr.e_bs  = 16'd0;
    vr.e_err = 8'd0;
    send_pkt(vr, PAY);
    repeat (2) @(negedge usb_clock);
    chk_fields("after_rst", vr);
    chk("sb_drained", sb.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end
endmodule
